alu_cmd_sequencer: RTL and testbench

Initiator-side front end for the team's 4-bit combinational ALU.
- Accepts tagged ALU commands (a, b, op) over a valid/ready stream and buffers them in a small in-order FIFO.
- Drives the ALU operand/opcode ports from registers and captures the ALU result and flags one cycle later.
- Returns each result with its tag on a valid/ready response stream with full backpressure.
- The ALU is instantiated outside this block and is connected port-to-port.

---
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the external 4-bit ALU: in-order command FIFO, registered ALU drive, tagged response capture.
// Latency: accept->pop 1 edge, pop->capture 1 edge. Backpressure: rsp held until rsp_ready, FIFO fill drops cmd_ready.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [7:0]       done_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
        logic [3:0]       b;
        logic [3:0]       a;
    } cmd_t;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t           state;
    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [TAG_W-1:0] tag_q;
    logic             push;
    logic             pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign cmd_ready = !rst && (count < (AW+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop       = (state == IDLE) && (count != '0) && (!rsp_valid || rsp_ready);
    assign busy      = (count != '0) || (state == EXEC) || rsp_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_tag, cmd_op, cmd_b, cmd_a};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tag_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_tag      <= '0;
            done_count   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_valid  <= 1'b0;
                done_count <= done_count + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + (AW+1)'(1);
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                        tag_q  <= head.tag;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has had a full cycle to settle on the registered operands.
                    rsp_result   <= alu_result;
                    rsp_carry    <= alu_carry;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_tag      <= tag_q;
                    rsp_valid    <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU stub and a queue-based response model.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [3:0]       a;
        logic [3:0]       b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_s;

    typedef struct packed {
        logic [3:0]       result;
        logic             carry;
        logic             zero;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } rsp_s;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic alu_carry, alu_zero, alu_overflow;
    logic rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic rsp_carry, rsp_zero, rsp_overflow;
    logic [TAG_W-1:0] rsp_tag;
    logic busy;
    logic [7:0] done_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    cmd_s txq[$];
    rsp_s rxq[$];
    int   rx_cyc[$];
    logic [2:0] opq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_tag(rsp_tag),
        .busy(busy), .done_count(done_count)
    );

    // ALU behaviour: carry/borrow and overflow only defined for ADD/SUB.
    function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia, ib, s;
        logic [3:0] r;
        logic c, v;
        ia = int'(a); ib = int'(b);
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin s = ia + ib; r = 4'(s); c = (s > 15);
                  v = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin s = ia - ib; r = 4'(s); c = (s < 0);
                  v = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = 4'(ia + 1);
            default: r = 4'(ia + 15);
        endcase
        return {r, c, (r == 4'h0), v};
    endfunction

    assign {alu_result, alu_carry, alu_zero, alu_overflow} = alu_fn(alu_a, alu_b, alu_op);

    function automatic cmd_s mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                input logic [TAG_W-1:0] tag);
        return '{a: a, b: b, op: op, tag: tag};
    endfunction

    function automatic rsp_s actual_rsp();
        return {rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_tag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input cmd_s c);
        cmd_valid = 1'b1;
        cmd_a = c.a; cmd_b = c.b; cmd_op = c.op; cmd_tag = c.tag;
    endtask

    // Drives txq as a valid/ready stream and records every response handshake.
    task automatic pump(input int ncyc, input int rdy_pct);
        logic fire_c, fire_r;
        logic [2:0] prev_op;
        prev_op = alu_op;
        for (int i = 0; i < ncyc; i++) begin
            if (txq.size() > 0) drive_cmd(txq[0]);
            else cmd_valid = 1'b0;
            rsp_ready = (int'($urandom_range(99)) < rdy_pct);
            fire_c = cmd_valid && cmd_ready;
            fire_r = rsp_valid && rsp_ready;
            if (fire_r) begin
                rxq.push_back(actual_rsp());
                rx_cyc.push_back(cyc);
            end
            step();
            if (fire_c) void'(txq.pop_front());
            if (alu_op != prev_op) begin
                opq.push_back(alu_op);
                prev_op = alu_op;
            end
            if (txq.size() == 0 && !busy) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        step(); step();
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
        vectors++;
        if ({rsp_valid, busy, alu_a, alu_b, alu_op, done_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b busy=%b a=%h b=%h op=%h dc=%0d want all 0",
                     rsp_valid, busy, alu_a, alu_b, alu_op, done_count);
        end
        vectors++;
        if (actual_rsp() !== '0) begin miscompares++; $display("FAIL reset_rsp got %h want 0", actual_rsp()); end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_cmd_ready got %b want 1", cmd_ready); end
        step();
    endtask

    task automatic test_add_latency();
        drive_cmd(mk(4'h7, 4'h9, 3'd0, 4'h1));
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL add_e0 got v=%b busy=%b want v=0 busy=1", rsp_valid, busy);
        end
        step();
        vectors++;
        if ({alu_a, alu_b, alu_op, rsp_valid} !== {4'h7, 4'h9, 3'd0, 1'b0}) begin
            miscompares++; $display("FAIL add_e1_drive got a=%h b=%h op=%h v=%b want 7 9 0 0",
                                    alu_a, alu_b, alu_op, rsp_valid);
        end
        step();
        vectors++;
        if ({rsp_valid, actual_rsp()} !== {1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h1}) begin
            miscompares++; $display("FAIL add_rsp got v=%b rsp=%h want v=1 rsp=%h",
                                    rsp_valid, actual_rsp(), {4'h0, 1'b1, 1'b1, 1'b0, 4'h1});
        end
        step();
        vectors++;
        if ({rsp_valid, busy, done_count} !== {1'b0, 1'b0, 8'd1}) begin
            miscompares++; $display("FAIL add_done got v=%b busy=%b dc=%0d want 0 0 1", rsp_valid, busy, done_count);
        end
    endtask

    task automatic test_sub_inc();
        txq = '{mk(4'h3, 4'h5, 3'd1, 4'h2), mk(4'hF, 4'h0, 3'd6, 4'h3)};
        rxq.delete(); rx_cyc.delete();
        pump(40, 100);
        vectors++;
        if (rxq.size() != 2) begin
            miscompares++; $display("FAIL sub_inc_count got %0d want 2", rxq.size());
        end else begin
            vectors++;
            if (rxq[0] !== {4'hE, 1'b1, 1'b0, 1'b0, 4'h2}) begin
                miscompares++; $display("FAIL sub_rsp got %h want %h", rxq[0], {4'hE, 1'b1, 1'b0, 1'b0, 4'h2});
            end
            vectors++;
            if (rxq[1] !== {4'h0, 1'b0, 1'b1, 1'b0, 4'h3}) begin
                miscompares++; $display("FAIL inc_rsp got %h want %h", rxq[1], {4'h0, 1'b0, 1'b1, 1'b0, 4'h3});
            end
        end
        vectors++;
        if (done_count !== 8'd3) begin miscompares++; $display("FAIL sub_inc_done got %0d want 3", done_count); end
    endtask

    task automatic test_fill_backpressure();
        rsp_s exp_r;
        txq.delete();
        for (int t = 0; t < 6; t++) txq.push_back(mk(4'(t), 4'h8, 3'd3, 4'(t)));
        rxq.delete(); rx_cyc.delete();
        pump(14, 0);
        vectors++;
        if (txq.size() != 1) begin
            miscompares++; $display("FAIL fill_accepted got %0d want 5", 6 - txq.size());
        end
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_tag, busy} !== {1'b0, 1'b1, 4'h0, 1'b1}) begin
            miscompares++; $display("FAIL fill_hold got rdy=%b v=%b tag=%h busy=%b want 0 1 0 1",
                                    cmd_ready, rsp_valid, rsp_tag, busy);
        end
        txq.delete();
        pump(40, 100);
        vectors++;
        if (rxq.size() != 5) begin
            miscompares++; $display("FAIL drain_count got %0d want 5", rxq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_r = {4'(8 + i), 3'b000, 4'(i)};
                vectors++;
                if (rxq[i] !== exp_r) begin
                    miscompares++; $display("FAIL drain_rsp%0d got %h want %h", i, rxq[i], exp_r);
                end
                if (i > 0) begin
                    vectors++;
                    if (rx_cyc[i] - rx_cyc[i-1] != 2) begin
                        miscompares++; $display("FAIL drain_spacing%0d got %0d want 2", i, rx_cyc[i] - rx_cyc[i-1]);
                    end
                end
            end
        end
        vectors++;
        if ({busy, done_count} !== {1'b0, 8'd8}) begin
            miscompares++; $display("FAIL drain_done got busy=%b dc=%0d want 0 8", busy, done_count);
        end
    endtask

    task automatic test_back_to_back();
        txq = '{mk(4'hA, 4'h5, 3'd4, 4'h6), mk(4'h0, 4'($urandom_range(15)), 3'd5, 4'h7)};
        rxq.delete(); rx_cyc.delete(); opq.delete();
        pump(40, 100);
        vectors++;
        if (rxq.size() != 2) begin
            miscompares++; $display("FAIL b2b_count got %0d want 2", rxq.size());
        end else begin
            vectors++;
            if (rxq[0] !== {4'hF, 3'b000, 4'h6} || rxq[1] !== {4'hF, 3'b000, 4'h7}) begin
                miscompares++; $display("FAIL b2b_rsp got %h %h want %h %h", rxq[0], rxq[1],
                                        {4'hF, 3'b000, 4'h6}, {4'hF, 3'b000, 4'h7});
            end
            vectors++;
            if (rx_cyc[1] - rx_cyc[0] != 2) begin
                miscompares++; $display("FAIL b2b_spacing got %0d want 2", rx_cyc[1] - rx_cyc[0]);
            end
        end
        vectors++;
        if (opq.size() != 2 || opq[0] !== 3'd4 || opq[1] !== 3'd5) begin
            miscompares++; $display("FAIL b2b_alu_op got n=%0d first=%0d want n=2 ops 4,5",
                                    opq.size(), (opq.size() > 0) ? opq[0] : 3'd0);
        end
        vectors++;
        if (done_count !== 8'd10) begin miscompares++; $display("FAIL b2b_done got %0d want 10", done_count); end
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(mk(4'(k + 1), 4'(k + 2), 3'd0, 4'(k + 8)));
            step();
        end
        drive_cmd(mk(4'h5, 4'h6, 3'd0, 4'hC));
        rsp_ready = 1'b1;
        step();
        vectors++;
        if ({rsp_valid, busy, alu_a} !== {1'b0, 1'b1, 4'h2}) begin
            miscompares++; $display("FAIL pre_rst_exec got v=%b busy=%b a=%h want 0 1 2", rsp_valid, busy, alu_a);
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
        step();
        vectors++;
        if ({rsp_valid, busy, alu_a, alu_b, alu_op, done_count} !== '0) begin
            miscompares++; $display("FAIL mid_rst_state got v=%b busy=%b a=%h b=%h op=%h dc=%0d want all 0",
                                    rsp_valid, busy, alu_a, alu_b, alu_op, done_count);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({rsp_valid, busy, done_count} !== '0) begin
                miscompares++; $display("FAIL stale_after_rst cycle %0d got v=%b busy=%b dc=%0d want 0 0 0",
                                        i, rsp_valid, busy, done_count);
            end
        end
    endtask

    task automatic test_random();
        rsp_s expq[$];
        rsp_s prev, exp_r;
        int acc, cmp;
        logic held, fire_c, fire_r;
        acc = 0; cmp = 0; held = 1'b0; prev = '0;
        for (int i = 0; i < 1700; i++) begin
            if (i < 1500) begin
                cmd_valid = (int'($urandom_range(99)) < 60);
                cmd_a = 4'($urandom_range(15)); cmd_b = 4'($urandom_range(15));
                cmd_op = 3'($urandom_range(7)); cmd_tag = 4'($urandom_range(15));
                rsp_ready = (int'($urandom_range(99)) < 50);
            end else begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            if (held) begin
                vectors++;
                if ({rsp_valid, actual_rsp()} !== {1'b1, prev}) begin
                    miscompares++; $display("FAIL rnd_hold cycle %0d got v=%b %h want v=1 %h",
                                            i, rsp_valid, actual_rsp(), prev);
                end
            end
            fire_c = cmd_valid && cmd_ready;
            fire_r = rsp_valid && rsp_ready;
            if (fire_r) begin
                exp_r = (expq.size() > 0) ? expq.pop_front() : '1;
                cmp++;
                vectors++;
                if (actual_rsp() !== exp_r) begin
                    miscompares++; $display("FAIL rnd_rsp #%0d got %h want %h", cmp, actual_rsp(), exp_r);
                end
            end
            if (fire_c) begin
                expq.push_back({alu_fn(cmd_a, cmd_b, cmd_op), cmd_tag});
                acc++;
            end
            held = rsp_valid && !rsp_ready;
            prev = actual_rsp();
            step();
            vectors++;
            if (busy !== (acc != cmp)) begin
                miscompares++; $display("FAIL rnd_busy cycle %0d got %b want %b", i, busy, acc != cmp);
            end
            vectors++;
            if (done_count !== 8'(cmp)) begin
                miscompares++; $display("FAIL rnd_done cycle %0d got %0d want %0d", i, done_count, 8'(cmp));
            end
        end
        vectors++;
        if (expq.size() != 0 || cmp < 300) begin
            miscompares++; $display("FAIL rnd_drain got pending=%0d completed=%0d want 0 pending, >=300 completed",
                                    expq.size(), cmp);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub_inc();
        test_fill_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
